fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the 16-entry, 32-bit pixel FIFO among several producer engines in the image processing accelerator. It grants one producer at a time for a bounded burst and drives the FIFO's write strobe and write data. It honours the FIFO full flag so that no beat is ever lost or duplicated. Rotating priority keeps any single producer from starving the others.

---
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional build macro FIFO_ARB_STALL_CNT_EN adds a saturating 16-bit stall counter output.
module fifo_wr_arbiter #(
    parameter int DW        = 32,
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    ack,
    input  logic                  fifo_full,
    output logic                  wr,
`ifdef FIFO_ARB_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic [DW-1:0]         data_fifo
);

    localparam int IW  = $clog2(NUM_REQ);
    localparam int BCW = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_reg;
    logic [NUM_REQ-1:0]  gnt_reg;
    logic [IW-1:0]       g_idx_reg;
    logic [IW-1:0]       rr_ptr_reg;
    logic [BCW-1:0]      beat_cnt_reg;

    logic [DW-1:0]       req_word [NUM_REQ];
    logic [IW-1:0]       idx_term [NUM_REQ];
    logic [NUM_REQ-1:0]  ptr_mask;
    logic [NUM_REQ-1:0]  req_hi;
    logic [NUM_REQ-1:0]  cand;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       next_ptr;
    logic                in_burst;
    logic                req_g;
    logic                last_g;
    logic                burst_end;

    assign in_burst = (state_reg == BURST);
    assign req_g    = req[g_idx_reg];
    assign last_g   = req_last[g_idx_reg];

    // Write path is purely combinational from the registered grant; a word
    // presented while reset is asserted must never reach the FIFO.
    assign wr        = in_burst & req_g & ~fifo_full & ~rst;
    assign data_fifo = in_burst ? req_word[g_idx_reg] : '0;
    assign gnt       = gnt_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign req_word[gi] = req_data[gi*DW +: DW];
            assign ack[gi]      = wr & (g_idx_reg == IW'(gi));
            assign idx_term[gi] = pick_oh[gi] ? IW'(gi) : '0;
        end
    endgenerate

    // Rotating priority: prefer requesters at or above rr_ptr, else wrap to
    // the lowest requester overall; the lowest set bit wins in either set.
    assign ptr_mask = ~((NUM_REQ'(1) << rr_ptr_reg) - NUM_REQ'(1));
    assign req_hi   = req & ptr_mask;
    assign cand     = (|req_hi) ? req_hi : req;
    assign pick_oh  = cand & (~cand + NUM_REQ'(1));

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pick_idx = pick_idx | idx_term[k];
        end
    end

    assign next_ptr  = (g_idx_reg == IW'(NUM_REQ - 1)) ? '0 : g_idx_reg + IW'(1);
    assign burst_end = ~req_g | (wr & (last_g | (beat_cnt_reg == BCW'(BURST_MAX - 1))));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            g_idx_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        state_reg    <= BURST;
                        gnt_reg      <= pick_oh;
                        g_idx_reg    <= pick_idx;
                        beat_cnt_reg <= '0;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        state_reg  <= IDLE;
                        gnt_reg    <= '0;
                        rr_ptr_reg <= next_ptr;
                    end
                    if (wr) begin
                        beat_cnt_reg <= beat_cnt_reg + BCW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (in_burst && req_g && fifo_full && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks of fifo_wr_arbiter against a transaction-level reference
// model; producer words encode {id, sequence} so lost or duplicated beats show up.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BM = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic            fifo_full;
    logic            wr;
    logic [DW-1:0]   data_fifo;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    fifo_wr_arbiter #(.DW(DW), .NUM_REQ(N), .BURST_MAX(BM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .gnt       (gnt),
        .ack       (ack),
        .fifo_full (fifo_full),
        .wr        (wr),
`ifdef FIFO_ARB_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .data_fifo (data_fifo)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Producer stimulus state
    int         avail   [N];
    int         pseq    [N];
    int         pkt_len [N];
    logic [N-1:0] en;

    // Reference model: current owner (-1 = none), pointer, beats, stalls
    int m_own   = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_stall = 0;

    // Observations taken from the DUT outputs
    int         grants     [$];
    int         grant_cyc  [$];
    int         burst_beats[$];
    int         cur_beats;
    int         wr_count;
    int         cyc;
    logic [N-1:0] gnt_prev;

    function automatic logic [DW-1:0] word_of(int i);
        logic [7:0]  id;
        logic [23:0] sq;
        id = 8'(i);
        sq = 24'(pseq[i]);
        return {id, sq};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]              = en[i] && (avail[i] > 0);
            req_data[i*DW +: DW] = word_of(i);
            req_last[i]         = (pkt_len[i] > 0) && ((pseq[i] % pkt_len[i]) == pkt_len[i] - 1);
        end
    endtask

    task automatic clear_obs();
        grants.delete();
        grant_cyc.delete();
        burst_beats.delete();
        cur_beats = 0;
        wr_count  = 0;
        cyc       = 0;
    endtask

    task automatic cycle();
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_ack;
        logic          e_wr;
        logic [DW-1:0] e_data;
        logic [N-1:0]  obs_ack;
        int            own_now;
        drive();
        @(negedge clk);
        e_gnt  = '0;
        e_ack  = '0;
        e_wr   = 1'b0;
        e_data = '0;
        if (m_own >= 0) begin
            e_gnt[m_own] = 1'b1;
            e_wr         = req[m_own] && !fifo_full && !rst;
            e_ack[m_own] = e_wr;
            e_data       = word_of(m_own);
        end
        check("gnt", 64'(gnt), 64'(e_gnt));
        check("wr", 64'(wr), 64'(e_wr));
        check("ack", 64'(ack), 64'(e_ack));
        check("data_fifo", 64'(data_fifo), 64'(e_data));
`ifdef FIFO_ARB_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        // Observation bookkeeping from DUT outputs
        if (gnt == '0 && gnt_prev != '0) begin
            burst_beats.push_back(cur_beats);
            cur_beats = 0;
        end
        if (gnt != '0 && gnt_prev == '0) begin
            for (int i = 0; i < N; i++) if (gnt[i]) grants.push_back(i);
            grant_cyc.push_back(cyc);
        end
        if (wr === 1'b1) begin
            cur_beats++;
            wr_count++;
            $display("cycle %0d: write gnt=%b data=%h", cyc, gnt, data_fifo);
        end
        gnt_prev = gnt;
        obs_ack  = ack;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (obs_ack[i] === 1'b1) begin
                avail[i]--;
                pseq[i]++;
            end
        end
        // Reference model advance
        own_now = m_own;
        if (rst) begin
            m_own = -1; m_ptr = 0; m_beats = 0; m_stall = 0;
        end else if (own_now < 0) begin
            if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_own < 0 && req[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
                end
                m_beats = 0;
            end
        end else begin
            if (req[own_now] && fifo_full && m_stall < 65535) m_stall++;
            if (!req[own_now]) begin
                m_own = -1;
            end else if (e_wr) begin
                m_beats++;
                if (req_last[own_now] || m_beats == BM) m_own = -1;
            end
            if (m_own < 0) m_ptr = (own_now + 1) % N;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fifo_full = 1'b0;
        en        = '0;
        for (int i = 0; i < N; i++) begin
            avail[i] = 0; pseq[i] = 0; pkt_len[i] = 0;
        end
        cycle();
        cycle();
        rst = 1'b0;
        clear_obs();
    endtask

    int wc0;

    initial begin
        rst = 1'b1; fifo_full = 1'b0; en = '0; gnt_prev = '0;
        for (int i = 0; i < N; i++) begin
            avail[i] = 0; pseq[i] = 0; pkt_len[i] = 0;
        end
        drive();
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_wr", 64'(wr), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_data", 64'(data_fifo), 64'd0);
`ifdef FIFO_ARB_STALL_CNT_EN
        check("rst_stall", 64'(stall_cnt), 64'd0);
`endif

        // Single producer, 3-word packet, then pointer must have moved to 1
        avail[0] = 3; pkt_len[0] = 3; en = 4'b0001;
        repeat (6) cycle();
        check("single_wr_count", 64'(wr_count), 64'd3);
        check("single_grant_id", 64'(grants[0]), 64'd0);
        check("single_grant_lat", 64'(grant_cyc[0]), 64'd1);
        check("single_beats", 64'(burst_beats[0]), 64'd3);
        avail[0] = 1; avail[1] = 1; pkt_len[0] = 0; en = 4'b0011;
        repeat (4) cycle();
        check("single_rr_next", 64'(grants[1]), 64'd1);

        // Round-robin with all four producers requesting continuously
        do_reset();
        for (int i = 0; i < N; i++) avail[i] = 100;
        en = 4'b1111;
        repeat (38) cycle();
        check("rr_ngrants", 64'(grants.size()), 64'd5);
        for (int i = 0; i < 5; i++) check("rr_order", 64'(grants[i]), 64'(i % N));
        for (int i = 0; i < 4; i++) check("rr_beats", 64'(burst_beats[i]), 64'(BM));
        check("rr_gap", 64'(grant_cyc[1] - grant_cyc[0]), 64'(BM + 1));

        // FIFO full for 5 cycles in the middle of producer 2's burst
        do_reset();
        avail[2] = 10; en = 4'b0100;
        repeat (3) cycle();
        wc0 = wr_count;
        fifo_full = 1'b1;
        repeat (5) cycle();
        check("stall_no_wr", 64'(wr_count), 64'(wc0));
        check("stall_gnt_held", 64'(gnt), 64'h4);
`ifdef FIFO_ARB_STALL_CNT_EN
        check("stall_cnt5", 64'(stall_cnt), 64'd5);
`endif
        fifo_full = 1'b0;
        repeat (3) cycle();
        check("stall_resume", 64'(wr_count), 64'(wc0 + 3));

        // Producer 1 drops its request after 2 beats; next winner is at or above 2
        do_reset();
        avail[0] = 10; avail[1] = 2; avail[3] = 10; en = 4'b0010;
        cycle();
        en = 4'b1011;
        repeat (6) cycle();
        check("drop_first", 64'(grants[0]), 64'd1);
        check("drop_beats", 64'(burst_beats[0]), 64'd2);
        check("drop_next", 64'(grants[1]), 64'd3);

        // Last word presented while the FIFO is full
        do_reset();
        avail[0] = 5; pkt_len[0] = 1; en = 4'b0001;
        cycle();
        fifo_full = 1'b1;
        repeat (2) cycle();
        check("lstall_gnt", 64'(gnt), 64'h1);
        check("lstall_nowr", 64'(wr_count), 64'd0);
        fifo_full = 1'b0;
        cycle();
        check("lstall_gnt_clr", 64'(gnt), 64'd0);
        check("lstall_wr1", 64'(wr_count), 64'd1);

        // Reset pulse during beat 4 of producer 3's burst
        do_reset();
        avail[3] = 10; en = 4'b1000;
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mrst_gnt", 64'(gnt), 64'd0);
        check("mrst_wr", 64'(wr), 64'd0);
        check("mrst_wr_count", 64'(wr_count), 64'd3);
        avail[0] = 4; en = 4'b1001;
        repeat (3) cycle();
        check("mrst_next", 64'(grants[1]), 64'd0);

        // Random traffic, full flag and rare resets
        do_reset();
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (avail[i] == 0) begin
                    avail[i]   = $urandom_range(1, 12);
                    pkt_len[i] = $urandom_range(0, 5);
                end
            end
            en        = N'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
